// File: rtl/cai_dev_queue_engine_if.sv
// Bus bundle between the queue engine and the outside world.
// Carries three groups of signals:
//   - word memory port   : mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in
//   - descriptor channel : desc_valid/desc_data out, desc_ready in
//   - done channel       : done_valid/done_status/done_ext/done_bytes in, done_ready out
// Handshake rule for every channel here: a transfer happens on the rising
// clock edge where the producer's valid/req and the consumer's ready/ack are
// both high; the producer holds its valid/req and payload unchanged until then.
// The master modport is the engine side; the slave modport is the memory and
// accelerator side.
interface cai_dev_queue_engine_if #(
  parameter int DESC_WORDS = 16
);
  logic                      mem_req;
  logic                      mem_we;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic                      mem_ack;

  logic                      desc_valid;
  logic                      desc_ready;
  logic [DESC_WORDS*32-1:0]  desc_data;

  logic                      done_valid;
  logic                      done_ready;
  logic [15:0]               done_status;
  logic [15:0]               done_ext;
  logic [31:0]               done_bytes;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output desc_valid, desc_data,
    input  desc_ready,
    input  done_valid, done_status, done_ext, done_bytes,
    output done_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  desc_valid, desc_data,
    output desc_ready,
    output done_valid, done_status, done_ext, done_bytes,
    input  done_ready
  );
endinterface

// File: rtl/cai_dev_queue_engine.sv
// Device queue engine: counts host doorbells, fetches one submit descriptor
// per job from a memory ring, hands it to an accelerator, waits for the
// result, writes a 4-word completion record to the completion ring and
// pulses comp_msg_o.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   submit_doorbell_i   : one job request per high cycle
//   bus (master)        : memory port, descriptor channel, done channel
//   comp_msg_o          : one-cycle completion notification
//   ready_o             : idle with nothing pending
//   pending_o           : queued doorbells (saturates at 255)
//   submit_idx_o        : descriptors dispatched so far
//   comp_idx_o          : completions written so far
//   overflow_o          : sticky, a doorbell arrived while pending was 255
//   state_o             : current FSM state (debug)
module cai_dev_queue_engine #(
  parameter logic [31:0] SUBMIT_BASE = 32'h0000_0400,
  parameter logic [31:0] COMP_BASE   = 32'h0000_0500,
  parameter logic [31:0] SUBMIT_MASK = 32'h0000_0000,
  parameter logic [31:0] COMP_MASK   = 32'h0000_0000,
  parameter int          DESC_WORDS  = 16,
  parameter int          TAG_WORD    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          submit_doorbell_i,
  cai_dev_queue_engine_if.master        bus,
  output logic                          comp_msg_o,
  output logic                          ready_o,
  output logic [7:0]                    pending_o,
  output logic [31:0]                   submit_idx_o,
  output logic [31:0]                   comp_idx_o,
  output logic                          overflow_o,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DISPATCH  = 3'd2,
    WAIT_DONE = 3'd3,
    WR_COMP   = 3'd4,
    MSG       = 3'd5
  } state_t;

  localparam logic [7:0]  LAST_RD    = 8'(DESC_WORDS - 1);
  localparam logic [31:0] DESC_BYTES = 32'(DESC_WORDS * 4);

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [DESC_WORDS*32-1:0] desc_q;
  logic [31:0]              tag_q;
  logic [15:0]              status_q;
  logic [15:0]              ext_q;
  logic [31:0]              bytes_q;
  logic [7:0]               pending_q;
  logic                     overflow_q;
  logic [31:0]              submit_idx_q;
  logic [31:0]              comp_idx_q;

  logic        take_job;
  logic        rd_fire;
  logic        desc_fire;
  logic        done_fire;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        desc_valid;
  logic        done_ready;
  logic        comp_msg;
  logic [31:0] submit_slot;
  logic [31:0] comp_slot;

  // Next state and outputs. Memory address/data are a pure function of the
  // state, the word counter and the ring indices; all three only move on an
  // ack edge, so the request stays stable while waiting for mem_ack.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take_job    = 1'b0;
    rd_fire     = 1'b0;
    desc_fire   = 1'b0;
    done_fire   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    desc_valid  = 1'b0;
    done_ready  = 1'b0;
    comp_msg    = 1'b0;
    submit_slot = (submit_idx_q & SUBMIT_MASK) * DESC_BYTES;
    comp_slot   = (comp_idx_q & COMP_MASK) << 4;
    case (state_q)
      IDLE: begin
        if (pending_q != 8'd0) begin
          take_job = 1'b1;
          cnt_d    = 8'd0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = SUBMIT_BASE + submit_slot + {22'd0, cnt_q, 2'b00};
        if (bus.mem_ack) begin
          rd_fire = 1'b1;
          if (cnt_q == LAST_RD) begin
            cnt_d   = 8'd0;
            state_d = DISPATCH;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DISPATCH: begin
        desc_valid = 1'b1;
        if (bus.desc_ready) begin
          desc_fire = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        done_ready = 1'b1;
        if (bus.done_valid) begin
          done_fire = 1'b1;
          cnt_d     = 8'd0;
          state_d   = WR_COMP;
        end
      end
      WR_COMP: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = COMP_BASE + comp_slot + {22'd0, cnt_q, 2'b00};
        case (cnt_q[1:0])
          2'd0:    mem_wdata = tag_q;
          2'd1:    mem_wdata = {ext_q, status_q};
          2'd2:    mem_wdata = bytes_q;
          default: mem_wdata = 32'h0;
        endcase
        if (bus.mem_ack) begin
          if (cnt_q == 8'd3) begin
            cnt_d   = 8'd0;
            state_d = MSG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      MSG: begin
        comp_msg = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Descriptor capture, one word per read ack; the tag word is kept
  // separately so the completion record survives a later descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_q <= '0;
      tag_q  <= 32'h0;
    end else if (rd_fire) begin
      for (int k = 0; k < DESC_WORDS; k++) begin
        if (cnt_q == 8'(k)) desc_q[k*32 +: 32] <= bus.mem_rdata;
      end
      if (cnt_q == 8'(TAG_WORD)) tag_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 16'h0;
      ext_q    <= 16'h0;
      bytes_q  <= 32'h0;
    end else if (done_fire) begin
      status_q <= bus.done_status;
      ext_q    <= bus.done_ext;
      bytes_q  <= bus.done_bytes;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      submit_idx_q <= 32'h0;
      comp_idx_q   <= 32'h0;
    end else begin
      if (desc_fire)        submit_idx_q <= submit_idx_q + 32'd1;
      if (state_q == MSG)   comp_idx_q   <= comp_idx_q + 32'd1;
    end
  end

  // Doorbell counter: a doorbell coinciding with a job start cancels out;
  // at saturation the doorbell is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      case ({submit_doorbell_i, take_job})
        2'b10: begin
          if (pending_q == 8'hFF) overflow_q <= 1'b1;
          else                    pending_q  <= pending_q + 8'd1;
        end
        2'b01:   pending_q <= pending_q - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.desc_valid = desc_valid;
  assign bus.desc_data  = desc_q;
  assign bus.done_ready = done_ready;

  assign comp_msg_o   = comp_msg;
  assign ready_o      = (state_q == IDLE) && (pending_q == 8'd0);
  assign pending_o    = pending_q;
  assign submit_idx_o = submit_idx_q;
  assign comp_idx_o   = comp_idx_q;
  assign overflow_o   = overflow_q;
  assign state_o      = state_q;

endmodule
